// File: rtl/spiscreen_pkg.sv
// Shared types and constants for the SPI LCD byte transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spiscreen_pkg;

    typedef enum logic [1:0] {
        ST_RST_LOW  = 2'd0,
        ST_RST_WAIT = 2'd1,
        ST_IDLE     = 2'd2,
        ST_SHIFT    = 2'd3
    } state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spiscreen_tx_if.sv
// Upstream byte handshake into the SPI LCD transmitter.
// Latency: n/a (wires only).
// Backpressure: out_ready from the transmitter; transfer on in_valid & out_ready.
interface spiscreen_tx_if;
    logic [7:0] in_byte;
    logic       in_dc;
    logic       in_valid;
    logic       out_ready;

    modport master (output in_byte, output in_dc, output in_valid, input out_ready);
    modport slave  (input in_byte, input in_dc, input in_valid, output out_ready);
endinterface

// File: rtl/spiscreen_shifter.sv
// Serializes one byte MSB-first in SPI mode 0 (sclk low half, then high half per bit).
// Latency: load at edge t -> bit 7 on mosi at t+1; byte lasts 16*CLK_DIV cycles.
// Backpressure: none; last_cycle marks the final cycle so a new load can follow with no gap.
module spiscreen_shifter #(
    parameter int CLK_DIV = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       sclk,
    output logic       mosi,
    output logic       last_cycle
);

    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       active;
    logic       phase_end;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            // Every cycle is a full sclk phase, so no divider is needed.
            assign phase_end = 1'b1;
        end else begin : g_div
            localparam int PW = $clog2(CLK_DIV);
            logic [PW-1:0] phase;

            // Phase counter: restarts on every new byte and wraps at the end of each half bit.
            always_ff @(posedge clock) begin
                if (reset || load || !active || phase_end) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 1'b1;
                end
            end

            assign phase_end = (phase == PW'(CLK_DIV - 1));
        end
    endgenerate

    // Shift engine: mosi only moves at the end of a high phase, i.e. together with sclk falling.
    always_ff @(posedge clock) begin
        if (reset) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
        end else if (load) begin
            active  <= 1'b1;
            sclk    <= 1'b0;
            shreg   <= byte_in;
            bit_idx <= 3'd7;
        end else if (active && phase_end) begin
            if (sclk) begin
                sclk <= 1'b0;
                if (bit_idx == 3'd0) begin
                    active <= 1'b0;
                    shreg  <= '0;
                end else begin
                    shreg   <= {shreg[6:0], 1'b0};
                    bit_idx <= bit_idx - 3'd1;
                end
            end else begin
                sclk <= 1'b1;
            end
        end
    end

    assign mosi       = shreg[7];
    assign last_cycle = active && sclk && phase_end && (bit_idx == 3'd0);

endmodule

// File: rtl/spiscreen_tx.sv
// SPI LCD byte transmitter: handshake, chip select, dc and optional panel reset (SPISCREEN_HWRST_EN).
// Latency: accept at edge t -> csn low with bit 7 at t+1; 16*CLK_DIV cycles per byte, no gap back-to-back.
// Backpressure: out_ready high in IDLE and in the final cycle of a byte; low during the reset sequence.
module spiscreen_tx
    import spiscreen_pkg::*;
#(
    parameter int CLK_DIV          = 1,
    parameter int RESN_LOW_CYCLES  = 1024,
    parameter int RESN_WAIT_CYCLES = 4096
) (
    input  logic           clock,
    input  logic           reset,
    spiscreen_tx_if.slave  up,
    output logic           out_busy,
    output logic           out_spi_clk,
    output logic           out_spi_csn,
    output logic           out_spi_dc,
    output logic           out_spi_mosi,
    output logic           out_spi_resn
);

    if (CLK_DIV < 1 || RESN_LOW_CYCLES < 1 || RESN_WAIT_CYCLES < 1) begin : g_bad_cfg
        $error("spiscreen_tx: CLK_DIV, RESN_LOW_CYCLES and RESN_WAIT_CYCLES must be >= 1");
    end

`ifdef SPISCREEN_HWRST_EN
    localparam state_t RESET_STATE   = ST_RST_LOW;
    localparam logic   RESN_AT_RESET = 1'b0;
`else
    localparam state_t RESET_STATE   = ST_IDLE;
    localparam logic   RESN_AT_RESET = 1'b1;
`endif

    state_t state_q, state_d;
    logic   ready;
    logic   load;
    logic   last_cycle;
    logic   csn_q;
    logic   dc_q;
    logic   resn_q;

`ifdef SPISCREEN_HWRST_EN
    localparam int RCW = $clog2(max_int(RESN_LOW_CYCLES, RESN_WAIT_CYCLES) + 1);
    logic [RCW-1:0] rst_cnt;

    // One down-counter times the resn-low window, then is reloaded for the post-reset wait.
    always_ff @(posedge clock) begin
        if (reset) begin
            rst_cnt <= RCW'(RESN_LOW_CYCLES - 1);
        end else if (state_q == ST_RST_LOW && rst_cnt == '0) begin
            rst_cnt <= RCW'(RESN_WAIT_CYCLES - 1);
        end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - 1'b1;
        end
    end
`endif

    // Next-state and handshake decode; ready depends only on state and the shifter position.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        load    = 1'b0;
        case (state_q)
`ifdef SPISCREEN_HWRST_EN
            ST_RST_LOW:  if (rst_cnt == '0) state_d = ST_RST_WAIT;
            ST_RST_WAIT: if (rst_cnt == '0) state_d = ST_IDLE;
`endif
            ST_IDLE: begin
                ready = 1'b1;
                if (up.in_valid) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ready = last_cycle;
                if (last_cycle) begin
                    if (up.in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pin registers; dc is captured with the byte and held until the byte ends.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RESET_STATE;
            csn_q   <= 1'b1;
            dc_q    <= DC_CMD;
            resn_q  <= RESN_AT_RESET;
        end else begin
            state_q <= state_d;
            csn_q   <= (state_d != ST_SHIFT);
            resn_q  <= (state_d != ST_RST_LOW);
            if (load) begin
                dc_q <= up.in_dc;
            end else if (state_d != ST_SHIFT) begin
                dc_q <= DC_CMD;
            end
        end
    end

    spiscreen_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .byte_in    (up.in_byte),
        .sclk       (out_spi_clk),
        .mosi       (out_spi_mosi),
        .last_cycle (last_cycle)
    );

    assign up.out_ready   = ready;
    assign out_spi_csn    = csn_q;
    assign out_spi_dc     = dc_q;
    assign out_spi_resn   = resn_q;
    assign out_busy       = ~csn_q | (state_q == ST_RST_LOW) | (state_q == ST_RST_WAIT);

endmodule

// File: tb/tb_spiscreen_tx.sv
// Bench for spiscreen_tx: three instances (CLK_DIV 1, 2, 3) against a timeline model and scoreboard.
// Latency: n/a.
// Backpressure: drivers hold in_valid with stable data until out_ready is seen.
module tb_spiscreen_tx;
`ifdef SPISCREEN_HWRST_EN
    localparam bit HW = 1'b1;
`else
    localparam bit HW = 1'b0;
`endif
    localparam int LOWC  = 8;
    localparam int WAITC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [7:0] in_byte [3];
    logic [2:0] in_dc, in_valid;
    logic [2:0] ready_w, busy_w, sclk_w, csn_w, dc_w, mosi_w, resn_w;

    int checks   = 0;
    int failures = 0;

    // Model: each DUT is either in its post-reset window, idle, or t cycles into a byte.
    bit         armed [3];
    bit         m_busy [3];
    int         m_t [3];
    int         m_rc [3];
    logic [7:0] m_byte [3];
    logic       m_dc [3];
    logic [8:0] exp_q [3][$];
    int         sb_n [3];
    logic [7:0] sb_sh [3];
    int         sb_match [3];
    bit         p_ok [3];
    logic       p_clk [3], p_csn [3], p_mosi [3], p_dc [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        spiscreen_tx_if bus ();
        assign bus.in_byte  = in_byte[k];
        assign bus.in_dc    = in_dc[k];
        assign bus.in_valid = in_valid[k];
        assign ready_w[k]   = bus.out_ready;
        spiscreen_tx #(.CLK_DIV(k + 1), .RESN_LOW_CYCLES(LOWC), .RESN_WAIT_CYCLES(WAITC)) dut (
            .clock        (clk),
            .reset        (rst[k]),
            .up           (bus),
            .out_busy     (busy_w[k]),
            .out_spi_clk  (sclk_w[k]),
            .out_spi_csn  (csn_w[k]),
            .out_spi_dc   (dc_w[k]),
            .out_spi_mosi (mosi_w[k]),
            .out_spi_resn (resn_w[k])
        );
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: pins vs model, mode-0 rules, and byte reconstruction from rising sclk.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [6:0] e, a;
            logic [8:0] want;
            int d2, bi;
            bit acc, rising;
            d2  = 2 * (k + 1);
            acc = 1'b0;
            if (armed[k]) begin
                if (HW && m_rc[k] < LOWC + WAITC) begin
                    e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (m_rc[k] >= LOWC)};
                end else if (!m_busy[k]) begin
                    e = 7'b1001001;
                end else begin
                    bi = 7 - m_t[k] / d2;
                    e = {(m_t[k] == 8 * d2 - 1), 1'b1, ((m_t[k] % d2) >= k + 1), 1'b0,
                         m_dc[k], m_byte[k][bi], 1'b1};
                end
                a = {ready_w[k], busy_w[k], sclk_w[k], csn_w[k], dc_w[k], mosi_w[k], resn_w[k]};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL pins dut%0d t=%0t rdy,busy,clk,csn,dc,mosi,resn got=%b expected=%b",
                             k, $time, a, e);
                end
                acc = e[6] && in_valid[k];
                if (p_ok[k] && p_clk[k] && sclk_w[k]) begin
                    checks++;
                    if (mosi_w[k] !== p_mosi[k] || dc_w[k] !== p_dc[k]) begin
                        failures++;
                        $display("FAIL hold_while_clk_high dut%0d t=%0t mosi=%b dc=%b was mosi=%b dc=%b",
                                 k, $time, mosi_w[k], dc_w[k], p_mosi[k], p_dc[k]);
                    end
                end
                if (p_ok[k] && p_csn[k] && csn_w[k]) begin
                    checks++;
                    if (sclk_w[k] !== p_clk[k]) begin
                        failures++;
                        $display("FAIL clk_idle_when_csn_high dut%0d t=%0t clk=%b was %b",
                                 k, $time, sclk_w[k], p_clk[k]);
                    end
                end
                rising = p_ok[k] && !p_clk[k] && sclk_w[k];
                if (csn_w[k]) begin
                    sb_n[k] = 0;
                end else if (rising) begin
                    sb_sh[k] = {sb_sh[k][6:0], mosi_w[k]};
                    sb_n[k]++;
                    if (sb_n[k] == 8) begin
                        sb_n[k] = 0;
                        checks++;
                        if (exp_q[k].size() == 0) begin
                            failures++;
                            $display("FAIL scoreboard dut%0d got=%h with no byte expected", k, sb_sh[k]);
                        end else begin
                            want = exp_q[k].pop_front();
                            if ({dc_w[k], sb_sh[k]} !== want) begin
                                failures++;
                                $display("FAIL scoreboard dut%0d got dc,byte=%h expected=%h",
                                         k, {dc_w[k], sb_sh[k]}, want);
                            end else begin
                                sb_match[k]++;
                            end
                        end
                    end
                end
                p_ok[k]   = 1'b1;
                p_clk[k]  = sclk_w[k];
                p_csn[k]  = csn_w[k];
                p_mosi[k] = mosi_w[k];
                p_dc[k]   = dc_w[k];
            end
            // Advance the model to the cycle after the coming clock edge.
            if (rst[k]) begin
                armed[k]  = 1'b1;
                m_busy[k] = 1'b0;
                m_rc[k]   = 0;
                sb_n[k]   = 0;
                exp_q[k].delete();
            end else if (armed[k]) begin
                if (m_rc[k] < LOWC + WAITC) m_rc[k]++;
                if (acc) begin
                    m_busy[k] = 1'b1;
                    m_t[k]    = 0;
                    m_byte[k] = in_byte[k];
                    m_dc[k]   = in_dc[k];
                    exp_q[k].push_back({in_dc[k], in_byte[k]});
                end else if (m_busy[k]) begin
                    if (m_t[k] == 8 * d2 - 1) m_busy[k] = 1'b0;
                    else m_t[k]++;
                end
            end
        end
    end

    // Drives up to two bytes on one DUT and records directly observed pin statistics.
    task automatic run_obs(input int k, input int ncyc,
                           input logic [7:0] b1, input logic d1,
                           input logic [7:0] b2, input logic d2, input int nbytes,
                           output int first_rdy, output int resn_low, output int rise_pre,
                           output int low_cyc, output int falls, output logic [15:0] bits,
                           output int dc1_at, output int accs);
        logic pclk, pcsn;
        bit acc;
        first_rdy = -1; resn_low = 0; rise_pre = 0; low_cyc = 0; falls = 0;
        bits = '0; dc1_at = -1; accs = 0; pclk = 1'b0; pcsn = 1'b1;
        in_byte[k] = b1; in_dc[k] = d1; in_valid[k] = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (ready_w[k] && first_rdy < 0) first_rdy = i;
            if (!resn_w[k]) resn_low++;
            if (!pclk && sclk_w[k] && first_rdy < 0) rise_pre++;
            if (!pclk && sclk_w[k] && !csn_w[k]) bits = {bits[14:0], mosi_w[k]};
            if (pcsn && !csn_w[k]) falls++;
            if (!csn_w[k]) begin
                low_cyc++;
                if (dc_w[k] && dc1_at < 0) dc1_at = low_cyc - 1;
            end
            acc  = ready_w[k] && in_valid[k];
            pclk = sclk_w[k];
            pcsn = csn_w[k];
            @(posedge clk); #1;
            if (acc) begin
                accs++;
                if (accs < nbytes) begin
                    in_byte[k] = b2; in_dc[k] = d2;
                end else begin
                    in_valid[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_ready(input int k, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (ready_w[k]) ok = 1'b1;
            n++;
        end
    endtask

    initial begin
        int fr, rl, rp, lc, fl, dca, ac;
        logic [15:0] bits;
        bit ok;
        rst = 3'b111;
        in_dc = '0;
        in_valid = '0;
        for (int k = 0; k < 3; k++) in_byte[k] = 8'h00;
        in_byte[0] = 8'hA5;
        in_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 3'b000;

        // 0xA5 with in_valid held from reset on CLK_DIV=1.
        run_obs(0, 60, 8'hA5, 1'b0, 8'h00, 1'b0, 1, fr, rl, rp, lc, fl, bits, dca, ac);
        check("first_ready_cycle", fr, HW ? LOWC + WAITC : 0);
        check("resn_low_cycles", rl, HW ? LOWC : 0);
        check("sclk_rises_before_ready", rp, 0);
        check("a5_bits", int'(bits[7:0]), 8'hA5);
        check("a5_csn_low_cycles", lc, 16);
        check("a5_csn_falls", fl, 1);
        check("a5_dc_never_high", dca, -1);
        check("a5_accepts", ac, 1);

        // Back-to-back 0x2A cmd then 0x3C data on CLK_DIV=2.
        run_obs(1, 100, 8'h2A, 1'b0, 8'h3C, 1'b1, 2, fr, rl, rp, lc, fl, bits, dca, ac);
        check("b2b_csn_low_cycles", lc, 64);
        check("b2b_csn_falls", fl, 1);
        check("b2b_bits", int'(bits), 16'h2A3C);
        check("b2b_dc_flip_index", dca, 32);
        check("b2b_accepts", ac, 2);

        // Reset in cycle 5 of a CLK_DIV=1 byte aborts it.
        in_byte[0] = 8'h3C; in_dc[0] = 1'b1; in_valid[0] = 1'b1;
        wait_ready(0, ok);
        check("abort_accept", int'(ok), 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(negedge clk);
        check("abort_mid_csn", int'(csn_w[0]), 0);
        check("abort_mid_clk", int'(sclk_w[0]), 1);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check("abort_csn", int'(csn_w[0]), 1);
        check("abort_clk", int'(sclk_w[0]), 0);
        check("abort_mosi", int'(mosi_w[0]), 0);
        @(posedge clk); #1;
        run_obs(0, 80, 8'hFF, 1'b1, 8'h00, 1'b0, 1, fr, rl, rp, lc, fl, bits, dca, ac);
        check("ff_bits", int'(bits[7:0]), 8'hFF);
        check("ff_csn_low_cycles", lc, 16);
        check("ff_dc_from_first_cycle", dca, 0);
        check("ff_accepts", ac, 1);

        // 200 random bytes with random idle gaps on CLK_DIV=3.
        for (int i = 0; i < 200; i++) begin
            int idle;
            idle = $urandom_range(0, 3);
            in_valid[2] = 1'b0;
            repeat (idle) begin
                in_byte[2] = 8'($urandom);
                @(posedge clk); #1;
            end
            in_byte[2]  = 8'($urandom);
            in_dc[2]    = 1'($urandom);
            in_valid[2] = 1'b1;
            wait_ready(2, ok);
            check("rand_accept", int'(ok), 1);
            @(posedge clk); #1;
        end
        in_valid[2] = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("rand_bytes_matched", sb_match[2], 200);
        check("rand_bytes_left", exp_q[2].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
